execute_alu_cc: RTL and testbench

//  Execute stage of the Y86-64 pipeline. Consumes decoded operands and drives the 64-bit ALU (add/sub/and/xor).

---
 rtl/y86_pkg.sv | 39 +++
 rtl/cond_eval.sv | 26 ++
 rtl/execute_alu_cc.sv | 152 +++++++++++++++
 tb/tb_execute_alu_cc.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage and the later PC-select logic.
package y86_pkg;

  localparam int unsigned WDefault = 64;

  localparam logic [3:0] IHalt   = 4'h0;
  localparam logic [3:0] INop    = 4'h1;
  localparam logic [3:0] IRrmovq = 4'h2;
  localparam logic [3:0] ICmovxx = 4'h2;
  localparam logic [3:0] IIrmovq = 4'h3;
  localparam logic [3:0] IRmmovq = 4'h4;
  localparam logic [3:0] IMrmovq = 4'h5;
  localparam logic [3:0] IOpq    = 4'h6;
  localparam logic [3:0] IJxx    = 4'h7;
  localparam logic [3:0] ICall   = 4'h8;
  localparam logic [3:0] IRet    = 4'h9;
  localparam logic [3:0] IPushq  = 4'hA;
  localparam logic [3:0] IPopq   = 4'hB;

  localparam logic [3:0] AluAdd = 4'h0;
  localparam logic [3:0] AluSub = 4'h1;
  localparam logic [3:0] AluAnd = 4'h2;
  localparam logic [3:0] AluXor = 4'h3;

  localparam logic [3:0] CondAlways = 4'h0;
  localparam logic [3:0] CondLe     = 4'h1;
  localparam logic [3:0] CondL      = 4'h2;
  localparam logic [3:0] CondE      = 4'h3;
  localparam logic [3:0] CondNe     = 4'h4;
  localparam logic [3:0] CondGe     = 4'h5;
  localparam logic [3:0] CondG      = 4'h6;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational jXX/cmovXX condition evaluation against a {ZF,SF,OF} snapshot.
module cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] ifun_i,
  input  cc_t        cc_i,
  output logic       cnd_o
);

  logic lt;

  always_comb begin
    lt = cc_i.sf ^ cc_i.of;
    case (ifun_i)
      CondAlways: cnd_o = 1'b1;
      CondLe:     cnd_o = lt | cc_i.zf;
      CondL:      cnd_o = lt;
      CondE:      cnd_o = cc_i.zf;
      CondNe:     cnd_o = ~cc_i.zf;
      CondGe:     cnd_o = ~lt;
      CondG:      cnd_o = ~lt & ~cc_i.zf;
      default:    cnd_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_alu_cc.sv
// Y86-64 execute stage: ALU, condition-code register, condition evaluation and E->M register.
// Define ALU_OVF_TRAP_EN to register the OF of CC-writing OPq instructions on ovf_trap.
module execute_alu_cc
  import y86_pkg::*;
#(
  parameter int unsigned W      = WDefault,
  parameter logic [2:0]  RST_CC = 3'b100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         stall,
  input  logic         bubble,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [W-1:0] valC,
  output logic         out_valid,
  output logic [3:0]   icode_o,
  output logic [W-1:0] valE,
  output logic         cnd,
  output logic [2:0]   cc,
  output logic         ovf_trap
);

  logic [W-1:0] alu_a, alu_b, alu_r;
  logic         alu_of, op_ok, cc_we, cnd_raw, cnd_calc;
  cc_t          cc_new;

  logic         out_valid_d, out_valid_q;
  logic [3:0]   icode_d, icode_q;
  logic [W-1:0] vale_d, vale_q;
  logic         cnd_d, cnd_q;
  cc_t          cc_d, cc_q;

  always_comb begin
    case (icode)
      IOpq, IRrmovq:            alu_a = valA;
      IIrmovq, IRmmovq, IMrmovq: alu_a = valC;
      ICall, IPushq:            alu_a = '0 - W'(8);
      IRet, IPopq:              alu_a = W'(8);
      default:                  alu_a = '0;
    endcase

    case (icode)
      IOpq, IRmmovq, IMrmovq, ICall, IPushq, IRet, IPopq: alu_b = valB;
      default:                                          alu_b = '0;
    endcase

    alu_r  = alu_b + alu_a;
    alu_of = (alu_a[W-1] == alu_b[W-1]) && (alu_r[W-1] != alu_b[W-1]);
    if (icode == IOpq) begin
      case (ifun)
        AluAdd: ;
        AluSub: begin
          alu_r  = alu_b - alu_a;
          alu_of = (alu_a[W-1] != alu_b[W-1]) && (alu_r[W-1] != alu_b[W-1]);
        end
        AluAnd: begin
          alu_r  = alu_b & alu_a;
          alu_of = 1'b0;
        end
        AluXor: begin
          alu_r  = alu_b ^ alu_a;
          alu_of = 1'b0;
        end
        default: begin
          alu_r  = '0;
          alu_of = 1'b0;
        end
      endcase
    end

    op_ok     = (icode == IOpq) && (ifun <= AluXor);
    cc_we     = in_valid & op_ok & ~stall & ~bubble & ~rst;
    cc_new.zf = (alu_r == '0);
    cc_new.sf = alu_r[W-1];
    cc_new.of = alu_of;
  end

  // Conditions see the CC from before this instruction's own update.
  cond_eval u_cond_eval (
    .ifun_i (ifun),
    .cc_i   (cc_q),
    .cnd_o  (cnd_raw)
  );

  assign cnd_calc = ((icode == IJxx) || (icode == ICmovxx)) & cnd_raw;

  always_comb begin
    out_valid_d = out_valid_q;
    icode_d     = icode_q;
    vale_d      = vale_q;
    cnd_d       = cnd_q;
    cc_d        = cc_we ? cc_new : cc_q;
    if (!stall) begin
      if (bubble || !in_valid) begin
        out_valid_d = 1'b0;
        icode_d     = INop;
        vale_d      = '0;
        cnd_d       = 1'b0;
      end else begin
        out_valid_d = 1'b1;
        icode_d     = icode;
        vale_d      = alu_r;
        cnd_d       = cnd_calc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      icode_q     <= INop;
      vale_q      <= '0;
      cnd_q       <= 1'b0;
      cc_q        <= cc_t'(RST_CC);
    end else begin
      out_valid_q <= out_valid_d;
      icode_q     <= icode_d;
      vale_q      <= vale_d;
      cnd_q       <= cnd_d;
      cc_q        <= cc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign icode_o   = icode_q;
  assign valE      = vale_q;
  assign cnd       = cnd_q;
  assign cc        = cc_q;

`ifdef ALU_OVF_TRAP_EN
  logic ovf_trap_d, ovf_trap_q;

  always_comb begin
    ovf_trap_d = ovf_trap_q;
    if (!stall) ovf_trap_d = cc_we & alu_of;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_trap_q <= 1'b0;
    else     ovf_trap_q <= ovf_trap_d;
  end

  assign ovf_trap = ovf_trap_q;
`else
  assign ovf_trap = 1'b0;
`endif

endmodule

// File: tb/tb_execute_alu_cc.sv
// Directed bench for execute_alu_cc: per-cycle compare against an instruction-level model,
// plus literal spot checks. Honours ALU_OVF_TRAP_EN for the ovf_trap expectation.
module tb_execute_alu_cc;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, bubble;
  logic [3:0]  icode, ifun;
  logic [63:0] valA, valB, valC;
  logic        out_valid, cnd, ovf_trap;
  logic [3:0]  icode_o;
  logic [63:0] valE;
  logic [2:0]  cc;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  execute_alu_cc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .stall     (stall),
    .bubble    (bubble),
    .icode     (icode),
    .ifun      (ifun),
    .valA      (valA),
    .valB      (valB),
    .valC      (valC),
    .out_valid (out_valid),
    .icode_o   (icode_o),
    .valE      (valE),
    .cnd       (cnd),
    .cc        (cc),
    .ovf_trap  (ovf_trap)
  );

  always #5 clk = ~clk;

`ifdef ALU_OVF_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  // Instruction-level reference model.
  logic        m_valid, m_cnd, m_ovf;
  logic [3:0]  m_icode;
  logic [63:0] m_vale, m_r;
  logic [2:0]  m_cc;
  logic [64:0] m_wide;
  logic        m_of, m_wr;

  function automatic logic cond_holds(input logic [3:0] fn, input logic [2:0] c);
    logic zf, sf, of;
    {zf, sf, of} = c;
    case (fn)
      4'd0:    return 1'b1;
      4'd1:    return (sf != of) || zf;
      4'd2:    return sf != of;
      4'd3:    return zf;
      4'd4:    return !zf;
      4'd5:    return sf == of;
      4'd6:    return (sf == of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b0; m_icode = 4'h1; m_vale = '0; m_cnd = 1'b0; m_ovf = 1'b0; m_cc = 3'b100;
    end else if (stall) begin
      // everything holds
    end else if (bubble || !in_valid) begin
      m_valid = 1'b0; m_icode = 4'h1; m_vale = '0; m_cnd = 1'b0; m_ovf = 1'b0;
    end else begin
      m_of = 1'b0;
      m_wr = 1'b0;
      case (icode)
        4'h6: begin
          m_wr = (ifun <= 4'd3);
          case (ifun)
            4'd0: begin m_wide = {valB[63], valB} + {valA[63], valA}; m_r = m_wide[63:0];
                        m_of = m_wide[64] != m_wide[63]; end
            4'd1: begin m_wide = {valB[63], valB} - {valA[63], valA}; m_r = m_wide[63:0];
                        m_of = m_wide[64] != m_wide[63]; end
            4'd2:    m_r = valB & valA;
            4'd3:    m_r = valB ^ valA;
            default: m_r = '0;
          endcase
        end
        4'h2:       m_r = valA;
        4'h3:       m_r = valC;
        4'h4, 4'h5: m_r = valB + valC;
        4'h8, 4'hA: m_r = valB - 64'd8;
        4'h9, 4'hB: m_r = valB + 64'd8;
        default:    m_r = '0;
      endcase
      m_cnd   = ((icode == 4'h7) || (icode == 4'h2)) ? cond_holds(ifun, m_cc) : 1'b0;
      m_valid = 1'b1;
      m_icode = icode;
      m_vale  = m_r;
      m_ovf   = TrapEn & m_wr & m_of;
      if (m_wr) m_cc = {m_r == 64'd0, m_r[63], m_of};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if ({out_valid, icode_o, valE, cnd, cc, ovf_trap} !==
          {m_valid, m_icode, m_vale, m_cnd, m_cc, m_ovf}) begin
        n_err++;
        $display("FAIL model t=%0t got v=%b i=%h e=%h c=%b cc=%b t=%b want v=%b i=%h e=%h c=%b cc=%b t=%b",
                 $time, out_valid, icode_o, valE, cnd, cc, ovf_trap,
                 m_valid, m_icode, m_vale, m_cnd, m_cc, m_ovf);
      end
    end
  end

  task automatic ck(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs; returns 1 time unit after the capturing edge.
  task automatic apply(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic st, input logic bb);
    in_valid = v; icode = ic; ifun = fn; valA = a; valB = b; valC = c; stall = st; bubble = bb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; bubble = 1'b0;
    icode = 4'h1; ifun = 4'h0; valA = '0; valB = '0; valC = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    ck("rst out_valid", 64'(out_valid), 64'd0);
    ck("rst icode_o", 64'(icode_o), 64'h1);
    ck("rst valE", valE, 64'd0);
    ck("rst cc", 64'(cc), 64'b100);
    rst = 1'b0;

    apply(1, 4'h6, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 0, 0, 0);
    ck("subq ovf valE", valE, 64'h7FFF_FFFF_FFFF_FFFF);
    ck("subq ovf out_valid", 64'(out_valid), 64'd1);
    ck("subq ovf cc", 64'(cc), 64'b001);
    apply(1, 4'h6, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 0);
    ck("addq ovf valE", valE, 64'h8000_0000_0000_0000);
    ck("addq ovf cc", 64'(cc), 64'b011);
    apply(1, 4'h7, 4'd2, 0, 0, 0, 0, 0);
    ck("jl cnd", 64'(cnd), 64'd0);
    apply(1, 4'h7, 4'd1, 0, 0, 0, 0, 0);
    ck("jle cnd", 64'(cnd), 64'd0);

    apply(1, 4'h6, 4'd1, 64'd420, 64'd420, 0, 0, 0);
    ck("subq eq cc", 64'(cc), 64'b100);
    apply(1, 4'h2, 4'd3, 64'd5, 0, 0, 0, 0);
    ck("cmove cnd", 64'(cnd), 64'd1);
    ck("cmove valE", valE, 64'd5);
    apply(1, 4'h7, 4'd4, 0, 0, 0, 0, 0);
    ck("jne cnd", 64'(cnd), 64'd0);

    apply(1, 4'hA, 4'd0, 0, 64'h100, 0, 0, 0);
    ck("pushq valE", valE, 64'hF8);
    ck("pushq cc", 64'(cc), 64'b100);
    apply(1, 4'hB, 4'd0, 0, 64'hF8, 0, 0, 0);
    ck("popq valE", valE, 64'h100);

    apply(1, 4'h6, 4'd1, 64'd3, 64'd10, 0, 0, 0);
    ck("subq 10-3 valE", valE, 64'd7);
    apply(1, 4'h6, 4'd1, 64'd3, 64'd3, 0, 1, 0);
    apply(1, 4'h6, 4'd1, 64'd3, 64'd3, 0, 1, 0);
    ck("stall valE", valE, 64'd7);
    ck("stall cc", 64'(cc), 64'b000);
    apply(1, 4'h6, 4'd1, 64'd3, 64'd3, 0, 1, 1);
    ck("stall+bubble out_valid", 64'(out_valid), 64'd1);
    apply(1, 4'h6, 4'd1, 64'd3, 64'd3, 0, 0, 1);
    ck("bubble out_valid", 64'(out_valid), 64'd0);
    ck("bubble icode_o", 64'(icode_o), 64'h1);
    ck("bubble cc", 64'(cc), 64'b000);
    apply(0, 4'h6, 4'd1, 64'd3, 64'd3, 0, 0, 0);

    apply(1, 4'h6, 4'd5, 64'd1, 64'd2, 0, 0, 0);
    ck("opq bad ifun valE", valE, 64'd0);
    ck("opq bad ifun cc", 64'(cc), 64'b000);
    apply(1, 4'h6, 4'd2, 64'hFF00, 64'hF0F0, 0, 0, 0);
    ck("andq valE", valE, 64'hF000);
    apply(1, 4'h6, 4'd3, 64'h1234, 64'h1234, 0, 0, 0);
    ck("xorq cc", 64'(cc), 64'b100);
    apply(1, 4'h7, 4'd0, 0, 0, 0, 0, 0);
    ck("jmp cnd", 64'(cnd), 64'd1);
    apply(1, 4'h7, 4'd7, 0, 0, 0, 0, 0);
    ck("j ifun7 cnd", 64'(cnd), 64'd0);
    apply(1, 4'h2, 4'd6, 64'd9, 0, 0, 0, 0);
    apply(1, 4'h3, 4'd0, 64'd1, 64'd2, 64'h55, 0, 0);
    ck("irmovq valE", valE, 64'h55);
    apply(1, 4'h5, 4'd0, 0, 64'h10, 64'h8, 0, 0);
    ck("mrmovq valE", valE, 64'h18);
    apply(1, 4'h8, 4'd0, 0, 64'h200, 0, 0, 0);
    ck("call valE", valE, 64'h1F8);

    apply(1, 4'h6, 4'd1, 64'd5, 64'd3, 0, 0, 0);
    ck("subq neg cc", 64'(cc), 64'b010);
    apply(1, 4'h7, 4'd2, 0, 0, 0, 0, 0);
    ck("jl neg cnd", 64'(cnd), 64'd1);
    apply(1, 4'h7, 4'd5, 0, 0, 0, 0, 0);
    apply(1, 4'h7, 4'd6, 0, 0, 0, 0, 0);

    apply(1, 4'h6, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 0);
    ck("ovf_trap", 64'(ovf_trap), 64'(TrapEn));
    rst = 1'b1;
    apply(1, 4'h6, 4'd0, 64'd1, 64'd1, 0, 1, 0);
    ck("mid rst out_valid", 64'(out_valid), 64'd0);
    ck("mid rst cc", 64'(cc), 64'b100);
    ck("mid rst ovf_trap", 64'(ovf_trap), 64'd0);
    rst = 1'b0;
    apply(0, 4'h1, 4'd0, 0, 0, 0, 0, 0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
